// File: rtl/mem_bist_master.sv
// Memory BIST initiator: writes a seed-derived pattern over an address range, reads it back and compares.
// Block mode writes the whole range, idles one cycle, then reads; consecutive mode writes then reads each address.
module mem_bist_master #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   num_locs,
   input  logic [WIDTH-1:0]      seed,
   output logic                  wr_rd,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [WIDTH-1:0]      wdata,
   output logic                  valid,
   input  logic                  ready,
   input  logic [WIDTH-1:0]      rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [ADDR_WIDTH:0]   err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]         TMO_ONE  = 1;
   localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

   typedef enum logic [2:0] {S_IDLE, S_BW, S_GAP, S_BR, S_CW, S_CR, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] cur_q, cur_d;
   logic [ADDR_WIDTH-1:0] first_q, first_d;
   logic [ADDR_WIDTH:0]   num_q, num_d;
   logic [ADDR_WIDTH:0]   left_q, left_d;
   logic [ADDR_WIDTH:0]   err_q, err_d;
   logic [WIDTH-1:0]      seed_q, seed_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  pass_q, pass_d;
   logic                  to_q, to_d;

   logic [WIDTH-1:0] cur_ext;
   logic [WIDTH-1:0] expect_dat;
   logic             hs;
   logic             last;

   always_comb begin
      cur_ext    = WIDTH'(cur_q);
      expect_dat = seed_q + cur_ext + (cur_ext << 3);
      valid      = (state_q == S_BW) || (state_q == S_BR) || (state_q == S_CW) || (state_q == S_CR);
      wr_rd      = (state_q == S_BW) || (state_q == S_CW);
      addr       = cur_q;
      wdata      = wr_rd ? expect_dat : '0;
      busy       = (state_q != S_IDLE) && (state_q != S_DONE);
      done       = (state_q == S_DONE);
      pass       = pass_q;
      timeout    = to_q;
      err_count  = err_q;
      first_err_addr = first_q;
      hs         = valid && ready;
      last       = (left_q == CNT_ONE);
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      cur_d   = cur_q;
      first_d = first_q;
      num_d   = num_q;
      left_d  = left_q;
      err_d   = err_q;
      seed_d  = seed_q;
      tmo_d   = tmo_q;
      pass_d  = pass_q;
      to_d    = to_q;

      // Per-beat wait counter; abort once a request has waited TIMEOUT cycles.
      if (valid) begin
         if (hs) begin
            tmo_d = '0;
         end else if (tmo_q == TMO_LAST) begin
            to_d    = 1'b1;
            state_d = S_DONE;
         end else begin
            tmo_d = tmo_q + TMO_ONE;
         end
      end

      if (hs && !wr_rd && (rdata != expect_dat)) begin
         err_d = err_q + CNT_ONE;
         if (err_q == '0) first_d = cur_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = start_addr;
               cur_d   = start_addr;
               num_d   = num_locs;
               left_d  = num_locs;
               seed_d  = seed;
               err_d   = '0;
               first_d = '0;
               to_d    = 1'b0;
               pass_d  = 1'b0;
               tmo_d   = '0;
               if (num_locs == '0)   state_d = S_DONE;
               else if (mode == 2'd1) state_d = S_CW;
               else                   state_d = S_BW;
            end
         end
         S_BW: begin
            if (hs) begin
               if (last) begin
                  state_d = S_GAP;
                  cur_d   = base_q;
                  left_d  = num_q;
               end else begin
                  cur_d  = cur_q + ADDR_ONE;
                  left_d = left_q - CNT_ONE;
               end
            end
         end
         S_GAP: state_d = S_BR;
         S_BR: begin
            if (hs) begin
               if (last) begin
                  state_d = S_DONE;
               end else begin
                  cur_d  = cur_q + ADDR_ONE;
                  left_d = left_q - CNT_ONE;
               end
            end
         end
         S_CW: begin
            if (hs) state_d = S_CR;
         end
         S_CR: begin
            if (hs) begin
               if (last) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_CW;
                  cur_d   = cur_q + ADDR_ONE;
                  left_d  = left_q - CNT_ONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Verdict is latched on DONE entry so it already reflects the final compare.
      if ((state_d == S_DONE) && (state_q != S_DONE)) pass_d = (err_d == '0) && !to_d;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         cur_q   <= '0;
         first_q <= '0;
         num_q   <= '0;
         left_q  <= '0;
         err_q   <= '0;
         seed_q  <= '0;
         tmo_q   <= '0;
         pass_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cur_q   <= cur_d;
         first_q <= first_d;
         num_q   <= num_d;
         left_q  <= left_d;
         err_q   <= err_d;
         seed_q  <= seed_d;
         tmo_q   <= tmo_d;
         pass_q  <= pass_d;
         to_q    <= to_d;
      end
   end
endmodule

// File: doc/mem_bist_master.md
Name: mem_bist_master

Overview:
- Synthesizable initiator for the valid/ready single-port memory interface (clk, res, wr_rd, addr, wdata, valid, ready, rdata).
- On a start pulse, it writes a deterministic data pattern over an address range, reads the range back and compares each word against the expected value.
- It reports pass/fail, error count, first failing address and timeout status.
- Sits in front of the memory responder as a built-in self-test engine and replaces bench-driven traffic.

Parameters:
- WIDTH, 8, data word width.
- DEPTH, 32, number of memory locations.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- TIMEOUT, 16, maximum cycles a request may wait for ready before the test aborts.

Ports:
- clk  input  1  single clock; all logic on posedge.
- res  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; starts a test when idle.
- mode  input  2  0=block (write all, then read all); 1=consecutive (write then read, per address); 2,3=reserved (treated as 0).
- start_addr  input  ADDR_WIDTH  first address.
- num_locs  input  ADDR_WIDTH+1  number of locations, 0..DEPTH.
- seed  input  WIDTH  pattern seed.
- wr_rd  output  1  1=write, 0=read.
- addr  output  ADDR_WIDTH  request address.
- wdata  output  WIDTH  write data.
- valid  output  1  request valid.
- ready  input  1  responder accepts the request; read data is valid in the same cycle.
- rdata  input  WIDTH  read data.
- busy  output  1  test in progress.
- done  output  1  one-cycle completion pulse.
- pass  output  1  last test had no miscompare and no timeout.
- timeout  output  1  last test aborted because ready never arrived.
- err_count  output  ADDR_WIDTH+1  miscompares in the last test.
- first_err_addr  output  ADDR_WIDTH  address of the first miscompare.

Behaviour:
- Reset: wr_rd, addr, wdata, valid, busy, done, pass, timeout, err_count and first_err_addr are all 0. State is IDLE.
- Reset mid-test takes effect at that same edge: valid drops and no done pulse is generated.
- All start inputs are sampled on the cycle start=1 in IDLE and held internally. start while busy is ignored.
- Pattern: expected/write data for address A is seed + A + (A << 3), truncated to WIDTH.
- Address sequence: start_addr, start_addr+1, … for num_locs locations, wrapping modulo 2^ADDR_WIDTH.
- States and transitions:
  - IDLE: on start, clear err_count, first_err_addr, timeout and pass. Then:
    - num_locs=0: go to DONE.
    - mode 1: go to CW.
    - otherwise: go to BW.
  - BW (block write): valid=1, wr_rd=1.
    - Handshake: valid&&ready at a posedge.
    - After the last write, go to GAP.
  - GAP: exactly one cycle with valid=0, then go to BR.
  - BR (block read): valid=1, wr_rd=0. On each handshake, compare rdata with the expected value. After the last read, go to DONE.
  - CW: write the current address. After the handshake, go to CR at the same address.
  - CR: read the same address and compare. After the handshake, advance to the next address and go to CW, or go to DONE after the last location.
  - DONE: valid=0, busy=0, done=1 for one cycle, pass = (err_count==0 && !timeout). Then go to IDLE.
- Timing:
  - busy=1 from the cycle after start until DONE.
  - The first request is presented the cycle after start.
- Handshake rules:
  - wr_rd, addr and wdata are stable while valid=1 && ready=0.
  - Back-to-back beats within a phase: a new request is presented in the cycle after the handshake, with valid held high.
  - wdata=0 during reads and in idle.
- Miscompare:
  - err_count increments by 1.
  - first_err_addr is loaded only on the first miscompare of a test.
- Timeout:
  - A per-beat counter clears on each handshake and on phase entry.
  - If valid has been high TIMEOUT cycles without ready, set timeout=1, drop valid and go to DONE, which gives pass=0.
- Status outputs hold until the next start.

Test Plan:
- Zero-wait responder, mode 0, start_addr=0, num_locs=32, seed=8'h00:
  - 32 writes with addr 0..31 and wdata=A*9 mod 256.
  - 1 gap cycle, then 32 reads.
  - done pulse with pass=1, err_count=0, busy low afterwards.
- mode 1, start_addr=20, num_locs=5, seed=8'h5A, responder with 2-cycle ready latency:
  - Sequence W20,R20,W21,R21,…,R24.
  - Signals held stable while waiting; pass=1.
- Wrap: mode 0, start_addr=30, num_locs=4:
  - Addresses 30,31,0,1 for both writes and reads; pass=1.
- Fault injection: responder returns rdata bit0 flipped at addresses 9 and 12; range 8..15 (start_addr=8, num_locs=8):
  - err_count=2, first_err_addr=9, pass=0.
- Timeout: responder never asserts ready:
  - valid drops after 16 cycles; done pulse with timeout=1 and pass=0.
- Edge cases:
  - num_locs=0: done pulse 1 cycle after start with pass=1 and no valid.
  - start while busy: ignored.
  - res asserted during BR: all outputs 0 on the next edge and no done pulse.
